// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared types for the FP operation-group result collector.
//   status_t    - IEEE exception flags reported with each result.
//   rob_state_e - lifecycle of one reorder-buffer entry.
package fpnew_pkg;

  typedef struct packed {
    logic nv;  // invalid operation
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;

  typedef enum logic [1:0] {
    Free    = 2'd0,
    Pending = 2'd1,
    Done    = 2'd2
  } rob_state_e;

endpackage

// File: rtl/fpnew_rob_entry.sv
// fpnew_rob_entry: one reorder-buffer slot (state machine plus payload storage).
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                drop the entry (wins over everything else)
//   alloc_i, tag_i         issue lands on this slot; tag is captured
//   complete_i, result_i,  a slice finished the op held here; payload captured
//   status_i, ext_bit_i
//   retire_i               this slot is head and is being consumed
//   state_o                current slot state
//   result_o, status_o,    stored payload
//   ext_bit_o, tag_o
module fpnew_rob_entry import fpnew_pkg::*; #(
  parameter int unsigned Width   = 64,
  parameter type         TagType = logic
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  TagType           tag_i,
  input  logic             complete_i,
  input  logic [Width-1:0] result_i,
  input  status_t          status_i,
  input  logic             ext_bit_i,
  input  logic             retire_i,
  output rob_state_e       state_o,
  output logic [Width-1:0] result_o,
  output status_t          status_o,
  output logic             ext_bit_o,
  output TagType           tag_o
);

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } payload_t;

  rob_state_e r_state, w_state_next;
  payload_t   r_payload;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= Free;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = Free;
    end else begin
      unique case (r_state)
        Free:    if (alloc_i)    w_state_next = Pending;
        Pending: if (complete_i) w_state_next = Done;
        Done:    if (retire_i)   w_state_next = Free;
        default: w_state_next = Free;
      endcase
    end
  end

  // Payload storage; cleared on reset so the output ports read zero afterwards
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_payload <= '0;
    end else if (!flush_i) begin
      if (r_state == Free && alloc_i) begin
        r_payload.tag <= tag_i;
      end
      if (r_state == Pending && complete_i) begin
        r_payload.result  <= result_i;
        r_payload.status  <= status_i;
        r_payload.ext_bit <= ext_bit_i;
      end
    end
  end

  // Outputs
  always_comb begin
    state_o   = r_state;
    result_o  = r_payload.result;
    status_o  = r_payload.status;
    ext_bit_o = r_payload.ext_bit;
    tag_o     = r_payload.tag;
  end

endmodule

// File: rtl/fpnew_opgroup_reorder.sv
// fpnew_opgroup_reorder: in-order result collector for an FP operation group whose
// format slices have different latencies. Each issue gets a buffer slot ID; slices
// complete out of order into their slot; results leave strictly in issue order.
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   in_valid_i/in_ready_o, tag_i   issue handshake and opaque op tag
//   alloc_id_o                     slot ID for the op being issued this cycle
//   slice_valid_i/id/result/status/ext_bit_i  per-slice completions
//   slice_ready_o                  always 1 out of reset (space reserved at issue)
//   flush_i                        drop every entry
//   out_valid_o/out_ready_i        head-result handshake
//   result_o, status_o, extension_bit_o, tag_o  head payload
//   busy_o                         any entry in use
module fpnew_opgroup_reorder import fpnew_pkg::*; #(
  parameter int unsigned NumSlices = 5,
  parameter int unsigned Width     = 64,
  parameter int unsigned Depth     = 4,
  parameter type         TagType   = logic,
  localparam int unsigned IdWidth  = $clog2(Depth)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  TagType                            tag_i,
  output logic [IdWidth-1:0]                alloc_id_o,
  input  logic [NumSlices-1:0]              slice_valid_i,
  input  logic [NumSlices-1:0][IdWidth-1:0] slice_id_i,
  input  logic [NumSlices-1:0][Width-1:0]   slice_result_i,
  input  status_t [NumSlices-1:0]           slice_status_i,
  input  logic [NumSlices-1:0]              slice_ext_bit_i,
  output logic [NumSlices-1:0]              slice_ready_o,
  input  logic                              flush_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [Width-1:0]                  result_o,
  output status_t                           status_o,
  output logic                              extension_bit_o,
  output TagType                            tag_o,
  output logic                              busy_o
);

  localparam int unsigned CntWidth = IdWidth + 1;

  logic [IdWidth-1:0]  r_head, r_tail;
  logic [CntWidth-1:0] r_count;
  logic                w_issue, w_retire;

  logic [Depth-1:0]    w_cpl_hit;
  logic [Width-1:0]    w_cpl_result [Depth];
  status_t             w_cpl_status [Depth];
  logic                w_cpl_ext    [Depth];

  rob_state_e          w_state  [Depth];
  logic [Width-1:0]    w_result [Depth];
  status_t             w_status [Depth];
  logic                w_ext    [Depth];
  TagType              w_tag    [Depth];

  assign in_ready_o    = rst_ni && (r_count != CntWidth'(Depth));
  assign slice_ready_o = {NumSlices{rst_ni}};
  assign alloc_id_o    = r_tail;
  assign busy_o        = (r_count != '0);
  assign w_issue       = in_valid_i && in_ready_o;
  assign w_retire      = out_valid_o && out_ready_i;

  // Pointers and occupancy; flush behaves like reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_issue)  r_tail <= r_tail + IdWidth'(1);
      if (w_retire) r_head <= r_head + IdWidth'(1);
      if (w_issue && !w_retire)      r_count <= r_count + CntWidth'(1);
      else if (!w_issue && w_retire) r_count <= r_count - CntWidth'(1);
    end
  end

  // Route each slice completion to the slot its ID names (IDs are unique per cycle)
  always_comb begin
    w_cpl_hit = '0;
    for (int e = 0; e < Depth; e++) begin
      w_cpl_result[e] = '0;
      w_cpl_status[e] = '0;
      w_cpl_ext[e]    = 1'b0;
      for (int s = 0; s < NumSlices; s++) begin
        if (slice_valid_i[s] && slice_id_i[s] == IdWidth'(e)) begin
          w_cpl_hit[e]    = 1'b1;
          w_cpl_result[e] = slice_result_i[s];
          w_cpl_status[e] = slice_status_i[s];
          w_cpl_ext[e]    = slice_ext_bit_i[s];
        end
      end
    end
  end

  for (genvar e = 0; e < Depth; e++) begin : g_entry
    fpnew_rob_entry #(
      .Width   (Width),
      .TagType (TagType)
    ) u_entry (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .alloc_i    (w_issue && (r_tail == IdWidth'(e))),
      .tag_i      (tag_i),
      .complete_i (w_cpl_hit[e]),
      .result_i   (w_cpl_result[e]),
      .status_i   (w_cpl_status[e]),
      .ext_bit_i  (w_cpl_ext[e]),
      .retire_i   (w_retire && (r_head == IdWidth'(e))),
      .state_o    (w_state[e]),
      .result_o   (w_result[e]),
      .status_o   (w_status[e]),
      .ext_bit_o  (w_ext[e]),
      .tag_o      (w_tag[e])
    );
  end

  // Head view; only registered state feeds these, so slice inputs never reach outputs
  always_comb begin
    out_valid_o     = rst_ni && (w_state[r_head] == Done);
    result_o        = w_result[r_head];
    status_o        = w_status[r_head];
    extension_bit_o = w_ext[r_head];
    tag_o           = w_tag[r_head];
  end

`ifndef SYNTHESIS
  for (genvar s = 0; s < NumSlices; s++) begin : g_chk
    a_cpl_pending: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      slice_valid_i[s] |-> (w_state[slice_id_i[s]] == Pending));
    for (genvar t = s + 1; t < NumSlices; t++) begin : g_pair
      a_cpl_unique: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        !(slice_valid_i[s] && slice_valid_i[t] && slice_id_i[s] == slice_id_i[t]));
    end
  end
`endif

endmodule
